// File: rtl/uart_rx_fifo_if.sv
// Handshake bundle between the UART receiver, the RX FIFO and the CPU-side
// register logic. The slave modport is the FIFO; the master drives it.
interface uart_rx_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic                  received;
  logic [7:0]            rx_byte;
  logic                  rx_error;
  logic                  rd_ack;
  logic                  status_clr;
  logic                  rd_valid;
  logic [6:0]            rd_data;
  logic [DEPTH_LOG2:0]   level;
  logic                  cts_hold;
  logic                  overflow;
  logic [7:0]            err_count;

  modport master (
    output received, rx_byte, rx_error, rd_ack, status_clr,
    input  rd_valid, rd_data, level, cts_hold, overflow, err_count
  );

  modport slave (
    input  received, rx_byte, rx_error, rd_ack, status_clr,
    output rd_valid, rd_data, level, cts_hold, overflow, err_count
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO with show-ahead head register and hysteretic CTS hold.
// Optional feature macro RX_LF_TO_CR_EN: store incoming LF (0x0A) as CR (0x0D).
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int CTS_HI     = 12,
  parameter int CTS_LO     = 4
) (
  input logic           clk,
  input logic           rst,
  uart_rx_fifo_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 1;
  localparam logic [LW-1:0]         DEPTH_L  = LW'(DEPTH);
  localparam logic [LW-1:0]         CTS_HI_L = LW'(CTS_HI);
  localparam logic [LW-1:0]         CTS_LO_L = LW'(CTS_LO);
  localparam logic [LW-1:0]         LVL_ONE  = LW'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HOLD = 1'b1
  } cts_state_e;

  function automatic logic [6:0] xlate(input logic [6:0] b);
`ifdef RX_LF_TO_CR_EN
    if (b == 7'h0A) begin
      return 7'h0D;
    end else begin
      return b;
    end
`else
    return b;
`endif
  endfunction

  logic [6:0]            mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [LW-1:0]         level_r;
  logic                  rd_valid_r;
  logic [6:0]            rd_data_r;
  logic                  overflow_r;
  logic [7:0]            err_count_r;
  cts_state_e            cts_state_r;
  logic                  cts_hold_r;

  logic                  full_s;
  logic                  push_req_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  ovf_evt_s;
  logic [6:0]            wr_data_s;
  logic [LW-1:0]         level_nxt_s;
  logic [DEPTH_LOG2-1:0] rd_ptr_nxt_s;
  logic [6:0]            head_nxt_s;
  logic                  rx_msb_unused_s;

  assign rx_msb_unused_s = bus.rx_byte[7];

  // Push/pop decode, next occupancy and next head (with write bypass).
  always_comb begin
    full_s      = (level_r == DEPTH_L);
    push_req_s  = bus.received & ~bus.rx_error;
    push_s      = push_req_s & ~full_s;
    ovf_evt_s   = push_req_s & full_s;
    pop_s       = bus.rd_ack & rd_valid_r;
    wr_data_s   = xlate(bus.rx_byte[6:0]);
    level_nxt_s = level_r;
    if (push_s && !pop_s) begin
      level_nxt_s = level_r + LVL_ONE;
    end else if (pop_s && !push_s) begin
      level_nxt_s = level_r - LVL_ONE;
    end else begin
      level_nxt_s = level_r;
    end
    rd_ptr_nxt_s = pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
    // The slot being written this cycle is not in mem_r yet, so forward it.
    if (push_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
      head_nxt_s = wr_data_s;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // Storage array; reset only makes entries unreachable.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data_s;
    end
  end

  // Pointers, occupancy, show-ahead head and sticky status.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      level_r     <= '0;
      rd_valid_r  <= 1'b0;
      rd_data_r   <= 7'h00;
      overflow_r  <= 1'b0;
      err_count_r <= 8'h00;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      rd_ptr_r   <= rd_ptr_nxt_s;
      level_r    <= level_nxt_s;
      rd_valid_r <= (level_nxt_s != '0);
      if (level_nxt_s != '0) begin
        rd_data_r <= head_nxt_s;
      end
      if (bus.status_clr) begin
        overflow_r  <= 1'b0;
        err_count_r <= 8'h00;
      end else begin
        if (ovf_evt_s) begin
          overflow_r <= 1'b1;
        end
        if (bus.rx_error && (err_count_r != 8'hFF)) begin
          err_count_r <= err_count_r + 8'h01;
        end
      end
    end
  end

  // Flow-control FSM: hysteresis between CTS_LO and CTS_HI on next level.
  always_ff @(posedge clk) begin
    if (rst) begin
      cts_state_r <= RUN;
      cts_hold_r  <= 1'b0;
    end else begin
      case (cts_state_r)
        RUN: begin
          if (level_nxt_s >= CTS_HI_L) begin
            cts_state_r <= HOLD;
            cts_hold_r  <= 1'b1;
          end
        end
        HOLD: begin
          if (level_nxt_s <= CTS_LO_L) begin
            cts_state_r <= RUN;
            cts_hold_r  <= 1'b0;
          end
        end
        default: begin
          cts_state_r <= RUN;
          cts_hold_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rd_valid  = rd_valid_r;
  assign bus.rd_data   = rd_data_r;
  assign bus.level     = level_r;
  assign bus.cts_hold  = cts_hold_r;
  assign bus.overflow  = overflow_r;
  assign bus.err_count = err_count_r;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized self-checking bench for uart_rx_fifo against a queue-based model.
module tb_uart_rx_fifo;
  localparam int DL    = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DEPTH_LOG2(DL)) bus ();
  uart_rx_fifo #(.DEPTH_LOG2(DL), .CTS_HI(12), .CTS_LO(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [6:0] q[$];
  bit         m_ovf;
  int         m_err;
  bit         m_hold;
  logic [6:0] m_shown;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] ref_xlate(input logic [7:0] b);
    logic [6:0] v;
    v = b[6:0];
`ifdef RX_LF_TO_CR_EN
    if (v == 7'h0A) v = 7'h0D;
`endif
    return v;
  endfunction

  task automatic compare_all();
    check_eq("rd_valid", 32'(bus.rd_valid), 32'(q.size() > 0));
    check_eq("rd_data", 32'(bus.rd_data), 32'(m_shown));
    check_eq("level", 32'(bus.level), 32'(q.size()));
    check_eq("cts_hold", 32'(bus.cts_hold), 32'(m_hold));
    check_eq("overflow", 32'(bus.overflow), 32'(m_ovf));
    check_eq("err_count", 32'(bus.err_count), 32'(m_err));
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf   = 1'b0;
    m_err   = 0;
    m_hold  = 1'b0;
    m_shown = 7'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    compare_all();
  endtask

  task automatic step(input bit rcv, input logic [7:0] b, input bit err, input bit ack, input bit clr);
    bit full0;
    bus.received   = rcv;
    bus.rx_byte    = b;
    bus.rx_error   = err;
    bus.rd_ack     = ack;
    bus.status_clr = clr;
    @(posedge clk); #1;
    bus.received   = 1'b0;
    bus.rx_error   = 1'b0;
    bus.rd_ack     = 1'b0;
    bus.status_clr = 1'b0;
    full0 = (q.size() == DEPTH);
    if (ack && q.size() > 0) void'(q.pop_front());
    if (err) begin
      if (m_err < 255) m_err++;
    end else if (rcv) begin
      if (full0) m_ovf = 1'b1;
      else q.push_back(ref_xlate(b));
    end
    if (clr) begin
      m_ovf = 1'b0;
      m_err = 0;
    end
    if (!m_hold && q.size() >= 12) m_hold = 1'b1;
    else if (m_hold && q.size() <= 4) m_hold = 1'b0;
    if (q.size() > 0) m_shown = q[0];
    compare_all();
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    int lv;
    int pp;
    logic [7:0] rb;
    bus.received   = 1'b0;
    bus.rx_byte    = 8'h00;
    bus.rx_error   = 1'b0;
    bus.rd_ack     = 1'b0;
    bus.status_clr = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    do_reset();

    // basic push/pop with bit-7 stripping
    step(1'b1, 8'hC1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
    check_eq("tp1_data0", 32'(bus.rd_data), 32'h41);
    check_eq("tp1_level2", 32'(bus.level), 32'd2);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check_eq("tp1_data1", 32'(bus.rd_data), 32'h42);
    check_eq("tp1_level1", 32'(bus.level), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check_eq("tp1_empty", 32'(bus.rd_valid), 32'd0);

    // overflow on the 17th byte
    for (int i = 0; i < 17; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
    check_eq("ovf_level", 32'(bus.level), 32'd16);
    check_eq("ovf_flag", 32'(bus.overflow), 32'd1);
    for (int i = 0; i < 16; i++) begin
      check_eq("ovf_order", 32'(bus.rd_data), 32'(8'h30 + i));
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    end
    check_eq("ovf_drained", 32'(bus.rd_valid), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // CTS hysteresis sweep
    for (int i = 0; i < 12; i++) step(1'b1, 8'(8'h61 + i), 1'b0, 1'b0, 1'b0);
    check_eq("cts_rise12", 32'(bus.cts_hold), 32'd1);
    for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check_eq("cts_hold5", 32'(bus.cts_hold), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check_eq("cts_fall4", 32'(bus.cts_hold), 32'd0);
    for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
    check_eq("cts_low11", 32'(bus.cts_hold), 32'd0);
    drain();

    // simultaneous push/pop at level 3 across pointer wrap
    for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'($urandom), 1'b0, 1'b1, 1'b0);
      check_eq("pushpop_level3", 32'(bus.level), 32'd3);
    end
    drain();

    // randomized traffic with varying fill bias
    for (int ph = 0; ph < 8; ph++) begin
      pp = (ph % 2 == 0) ? 75 : 30;
      for (int i = 0; i < 200; i++) begin
        rb = 8'($urandom);
        step(($urandom_range(0, 99) < pp), rb, ($urandom_range(0, 15) == 0),
             ($urandom_range(0, 99) < 100 - pp), ($urandom_range(0, 63) == 0));
      end
    end
    drain();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // error counter saturation and error-with-byte
    for (int i = 0; i < 300; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check_eq("err_sat", 32'(bus.err_count), 32'd255);
    lv = int'(bus.level);
    step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    check_eq("err_nopush", 32'(bus.level), 32'(lv));
    for (int i = 0; i < 17; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check_eq("clr_err", 32'(bus.err_count), 32'd0);
    check_eq("clr_ovf", 32'(bus.overflow), 32'd0);
    drain();

    // LF translation
    step(1'b1, 8'h0A, 1'b0, 1'b0, 1'b0);
`ifdef RX_LF_TO_CR_EN
    check_eq("lf_xlate", 32'(bus.rd_data), 32'h0D);
`else
    check_eq("lf_xlate", 32'(bus.rd_data), 32'h0A);
`endif
    drain();

    // reset mid-operation at level 5
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h70 + i), 1'b0, 1'b0, 1'b0);
    check_eq("pre_rst_level5", 32'(bus.level), 32'd5);
    do_reset();
    check_eq("rst_level", 32'(bus.level), 32'd0);
    check_eq("rst_valid", 32'(bus.rd_valid), 32'd0);
    step(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
